// File: rtl/sprite_engine.sv
// Multi-object sprite controller: UART byte commands move and steer N_OBJ square
// objects, and a one-cycle pixel stage colours border and objects from VGA timing.
module sprite_engine #(
  parameter int N_OBJ    = 4,
  parameter int OBJ_SIZE = 100,
  parameter int STEP     = 4,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int BORDER   = 10,
  parameter int X0       = 40,
  parameter int X_PITCH  = 120,
  parameter int Y0       = 240,
  parameter int WRAP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  input  logic             blank,
  input  logic             frame_tick,
  output logic [1:0]       R,
  output logic [1:0]       G,
  output logic [1:0]       B,
  output logic [N_OBJ-1:0] obj_hit,
  output logic [2:0]       sel
);

  localparam logic [7:0] CMD_W  = 8'd119, CMD_S  = 8'd115, CMD_A  = 8'd97,  CMD_D  = 8'd100;
  localparam logic [7:0] CMD_UW = 8'd87,  CMD_US = 8'd83,  CMD_UA = 8'd65,  CMD_UD = 8'd68;
  localparam logic [7:0] CMD_X  = 8'd120, CMD_R  = 8'd114;
  localparam logic [1:0] VEL_ZERO = 2'b00, VEL_POS = 2'b01, VEL_NEG = 2'b11;

  localparam logic [9:0]  STEP10 = 10'(STEP);
  localparam logic [9:0]  X_MAX  = 10'(H_RES - OBJ_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_RES - OBJ_SIZE);
  localparam logic [10:0] SIZE11 = 11'(OBJ_SIZE);
  localparam logic [9:0]  BORDER10 = 10'(BORDER);
  localparam logic [9:0]  H_RES10 = 10'(H_RES), V_RES10 = 10'(V_RES);
  localparam logic [9:0]  H_IN = 10'(H_RES - BORDER), V_IN = 10'(V_RES - BORDER);

  // Returns {clamped, new_pos}; clamped is only ever set in clamp mode.
  function automatic logic [10:0] step_pos(input logic [9:0] pos, input logic up,
                                           input logic [9:0] lim);
    logic [10:0] sum;
    logic [10:0] res;
    sum = {1'b0, pos} + {1'b0, STEP10};
    if (WRAP != 0)
      res = up ? {1'b0, sum[9:0]} : {1'b0, pos - STEP10};
    else if (up)
      res = (sum > {1'b0, lim}) ? {1'b1, lim} : {1'b0, sum[9:0]};
    else
      res = (pos < STEP10) ? {1'b1, 10'd0} : {1'b0, pos - STEP10};
    return res;
  endfunction

  logic [2:0]       sel_reg;
  logic [1:0]       r_reg, g_reg, b_reg;
  logic [N_OBJ-1:0] obj_hit_reg;
  logic [N_OBJ-1:0] hit_comb;
  logic [7:0]       hit_ext;
  logic             cmd_r, obj_cmd, sel_cmd, border_comb, sel_hit;

  assign cmd_r   = rx_done && (rx_data == CMD_R);
  assign sel_cmd = rx_done && (rx_data >= 8'd48) && (rx_data <= 8'd55) &&
                   ({1'b0, rx_data[2:0]} < 4'(N_OBJ));

  always_comb begin
    obj_cmd = 1'b0;
    case (rx_data)
      CMD_W, CMD_S, CMD_A, CMD_D, CMD_UW, CMD_US, CMD_UA, CMD_UD, CMD_X: obj_cmd = 1'b1;
      default: obj_cmd = 1'b0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OBJ; gi++) begin : g_obj
      localparam logic [9:0] RST_X = 10'(X0 + gi * X_PITCH);
      localparam logic [9:0] RST_Y = 10'(Y0);

      logic [9:0]  ox_reg, oy_reg, ox_next, oy_next;
      logic [1:0]  vx_reg, vy_reg, vx_next, vy_next;
      logic        is_target, x_up, y_up;
      logic [10:0] mx, my;

      // One stepper per axis serves both nudges and auto-motion; a commanded
      // object never auto-moves in the same cycle, so they cannot collide.
      assign is_target = rx_done && obj_cmd && (sel_reg == 3'(gi));
      assign x_up = is_target ? (rx_data == CMD_D) : (vx_reg == VEL_POS);
      assign y_up = is_target ? (rx_data == CMD_S) : (vy_reg == VEL_POS);
      assign mx = step_pos(ox_reg, x_up, X_MAX);
      assign my = step_pos(oy_reg, y_up, Y_MAX);

      always_comb begin
        ox_next = ox_reg;
        oy_next = oy_reg;
        vx_next = vx_reg;
        vy_next = vy_reg;
        if (cmd_r) begin
          ox_next = RST_X;
          oy_next = RST_Y;
          vx_next = VEL_ZERO;
          vy_next = VEL_ZERO;
        end else if (is_target) begin
          case (rx_data)
            CMD_A, CMD_D: ox_next = mx[9:0];
            CMD_W, CMD_S: oy_next = my[9:0];
            CMD_UA: vx_next = VEL_NEG;
            CMD_UD: vx_next = VEL_POS;
            CMD_UW: vy_next = VEL_NEG;
            CMD_US: vy_next = VEL_POS;
            CMD_X: begin
              vx_next = VEL_ZERO;
              vy_next = VEL_ZERO;
            end
            default: ;
          endcase
        end else if (frame_tick) begin
          if (vx_reg != VEL_ZERO) begin
            ox_next = mx[9:0];
            if (mx[10]) vx_next = VEL_ZERO;
          end
          if (vy_reg != VEL_ZERO) begin
            oy_next = my[9:0];
            if (my[10]) vy_next = VEL_ZERO;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ox_reg <= RST_X;
          oy_reg <= RST_Y;
          vx_reg <= VEL_ZERO;
          vy_reg <= VEL_ZERO;
        end else begin
          ox_reg <= ox_next;
          oy_reg <= oy_next;
          vx_reg <= vx_next;
          vy_reg <= vy_next;
        end
      end

      // 11-bit upper bound so an object near 1023 is not falsely wrapped.
      assign hit_comb[gi] = !blank &&
                            (x > ox_reg) && ({1'b0, x} < ({1'b0, ox_reg} + SIZE11)) &&
                            (y > oy_reg) && ({1'b0, y} < ({1'b0, oy_reg} + SIZE11));
    end
  endgenerate

  assign hit_ext = 8'(hit_comb);
  assign sel_hit = hit_ext[sel_reg];
  assign border_comb = ((x > 10'd0) && (x < BORDER10)) || ((x > H_IN) && (x < H_RES10)) ||
                       ((y > 10'd0) && (y < BORDER10)) || ((y > V_IN) && (y < V_RES10));

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg     <= 3'd0;
      obj_hit_reg <= '0;
      r_reg       <= 2'b00;
      g_reg       <= 2'b00;
      b_reg       <= 2'b00;
    end else begin
      if (sel_cmd) sel_reg <= rx_data[2:0];
      obj_hit_reg <= hit_comb;
      if (blank) begin
        r_reg <= 2'b00; g_reg <= 2'b00; b_reg <= 2'b00;
      end else if (border_comb || sel_hit) begin
        r_reg <= 2'b11; g_reg <= 2'b11; b_reg <= 2'b11;
      end else if (|hit_comb) begin
        r_reg <= 2'b00; g_reg <= 2'b11; b_reg <= 2'b00;
      end else begin
        r_reg <= 2'b00; g_reg <= 2'b00; b_reg <= 2'b00;
      end
    end
  end

  assign sel     = sel_reg;
  assign obj_hit = obj_hit_reg;
  assign R       = r_reg;
  assign G       = g_reg;
  assign B       = b_reg;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine: dut0 uses defaults, dut1 has X0=2 (wrap),
// dut2 has WRAP=0 (clamp). Pixel results are compared as {obj_hit, R, G, B}.
module tb_sprite_engine;
  localparam logic [5:0] NONE = 6'b000000, WHT = 6'b111111, GRN = 6'b001100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data [3];
  logic       rx_done [3];
  logic [9:0] px [3];
  logic [9:0] py [3];
  logic       blank [3];
  logic       frame_tick [3];
  logic [1:0] r_o [3];
  logic [1:0] g_o [3];
  logic [1:0] b_o [3];
  logic [3:0] hit_o [3];
  logic [2:0] sel_o [3];
  logic [9:0] pix [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) pix[i] = {hit_o[i], r_o[i], g_o[i], b_o[i]};
  end

  sprite_engine u_dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data[0]), .rx_done(rx_done[0]),
    .x(px[0]), .y(py[0]), .blank(blank[0]), .frame_tick(frame_tick[0]),
    .R(r_o[0]), .G(g_o[0]), .B(b_o[0]), .obj_hit(hit_o[0]), .sel(sel_o[0]));

  sprite_engine #(.X0(2)) u_dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data[1]), .rx_done(rx_done[1]),
    .x(px[1]), .y(py[1]), .blank(blank[1]), .frame_tick(frame_tick[1]),
    .R(r_o[1]), .G(g_o[1]), .B(b_o[1]), .obj_hit(hit_o[1]), .sel(sel_o[1]));

  sprite_engine #(.WRAP(0)) u_dut2 (
    .clk(clk), .reset(reset), .rx_data(rx_data[2]), .rx_done(rx_done[2]),
    .x(px[2]), .y(py[2]), .blank(blank[2]), .frame_tick(frame_tick[2]),
    .R(r_o[2]), .G(g_o[2]), .B(b_o[2]), .obj_hit(hit_o[2]), .sel(sel_o[2]));

  task automatic send(input int d, input logic [7:0] b);
    @(negedge clk); rx_data[d] = b; rx_done[d] = 1'b1;
    @(negedge clk); rx_done[d] = 1'b0;
    $display("rx   dut%0d byte 0x%02h sel=%0d", d, b, sel_o[d]);
  endtask

  task automatic send_n(input int d, input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); rx_data[d] = b; rx_done[d] = 1'b1;
    end
    @(negedge clk); rx_done[d] = 1'b0;
    $display("rx   dut%0d byte 0x%02h x%0d", d, b, n);
  endtask

  task automatic tick(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); frame_tick[d] = 1'b1;
      @(negedge clk); frame_tick[d] = 1'b0;
    end
    $display("tick dut%0d x%0d", d, n);
  endtask

  task automatic probe(input int d, input logic [9:0] xx, input logic [9:0] yy, input logic bl);
    @(negedge clk); px[d] = xx; py[d] = yy; blank[d] = bl;
    @(negedge clk);
    $display("pix  dut%0d (%0d,%0d) blank=%0b hit=%b rgb=%b", d, xx, yy, bl, hit_o[d], pix[d][5:0]);
  endtask

  task automatic test_reset;
    px[0] = 10'd41; py[0] = 10'd241; blank[0] = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pix[0] !== {4'b0000, NONE} || sel_o[0] !== 3'd0) begin errors++;
      $display("FAIL reset_outputs got %b sel %0d exp %b sel 0", pix[0], sel_o[0], {4'b0000, NONE}); end
    reset = 1'b0;
    probe(0, 41, 241, 0);
    checks++; if (pix[0] !== {4'b0001, WHT}) begin errors++; $display("FAIL reset_obj0 got %b exp %b", pix[0], {4'b0001, WHT}); end
    probe(0, 40, 241, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL obj0_left_edge got %b exp %b", pix[0], {4'b0000, NONE}); end
    probe(0, 139, 241, 0);
    checks++; if (pix[0] !== {4'b0001, WHT}) begin errors++; $display("FAIL obj0_right_in got %b exp %b", pix[0], {4'b0001, WHT}); end
    probe(0, 140, 241, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL obj0_right_out got %b exp %b", pix[0], {4'b0000, NONE}); end
    probe(0, 161, 241, 0);
    checks++; if (pix[0] !== {4'b0010, GRN}) begin errors++; $display("FAIL reset_obj1 got %b exp %b", pix[0], {4'b0010, GRN}); end
    probe(0, 5, 300, 0);
    checks++; if (pix[0] !== {4'b0000, WHT}) begin errors++; $display("FAIL border_left got %b exp %b", pix[0], {4'b0000, WHT}); end
    probe(0, 635, 475, 0);
    checks++; if (pix[0] !== {4'b0000, WHT}) begin errors++; $display("FAIL border_corner got %b exp %b", pix[0], {4'b0000, WHT}); end
    probe(0, 41, 241, 1);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL blank got %b exp %b", pix[0], {4'b0000, NONE}); end
  endtask

  task automatic test_select_nudge;
    send(0, "2");
    checks++; if (sel_o[0] !== 3'd2) begin errors++; $display("FAIL sel_2 got %0d exp 2", sel_o[0]); end
    send(0, "d");
    probe(0, 284, 241, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL nudge_d_out got %b exp %b", pix[0], {4'b0000, NONE}); end
    probe(0, 285, 241, 0);
    checks++; if (pix[0] !== {4'b0100, WHT}) begin errors++; $display("FAIL nudge_d_in got %b exp %b", pix[0], {4'b0100, WHT}); end
    probe(0, 383, 241, 0);
    checks++; if (pix[0] !== {4'b0100, WHT}) begin errors++; $display("FAIL nudge_d_right got %b exp %b", pix[0], {4'b0100, WHT}); end
    probe(0, 41, 241, 0);
    checks++; if (pix[0] !== {4'b0001, GRN}) begin errors++; $display("FAIL obj0_unsel got %b exp %b", pix[0], {4'b0001, GRN}); end
    send(0, "9");
    checks++; if (sel_o[0] !== 3'd2) begin errors++; $display("FAIL sel_9_ignored got %0d exp 2", sel_o[0]); end
    send(0, "4");
    checks++; if (sel_o[0] !== 3'd2) begin errors++; $display("FAIL sel_4_range got %0d exp 2", sel_o[0]); end
    send(0, "w");
    probe(0, 300, 237, 0);
    checks++; if (pix[0] !== {4'b0100, WHT}) begin errors++; $display("FAIL nudge_w_in got %b exp %b", pix[0], {4'b0100, WHT}); end
    probe(0, 300, 236, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL nudge_w_out got %b exp %b", pix[0], {4'b0000, NONE}); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); rx_data[0] = "1"; rx_done[0] = 1'b1;
    @(negedge clk); rx_data[0] = "d";
    @(negedge clk); rx_data[0] = "d";
    @(negedge clk); rx_done[0] = 1'b0;
    $display("rx   dut0 bytes '1','d','d' back-to-back sel=%0d", sel_o[0]);
    checks++; if (sel_o[0] !== 3'd1) begin errors++; $display("FAIL b2b_sel got %0d exp 1", sel_o[0]); end
    probe(0, 168, 241, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL b2b_out got %b exp %b", pix[0], {4'b0000, NONE}); end
    probe(0, 169, 241, 0);
    checks++; if (pix[0] !== {4'b0010, WHT}) begin errors++; $display("FAIL b2b_in got %b exp %b", pix[0], {4'b0010, WHT}); end
  endtask

  task automatic test_cmd_reset;
    send(0, "r");
    checks++; if (sel_o[0] !== 3'd1) begin errors++; $display("FAIL r_keeps_sel got %0d exp 1", sel_o[0]); end
    probe(0, 281, 241, 0);
    checks++; if (pix[0] !== {4'b0100, GRN}) begin errors++; $display("FAIL r_obj2 got %b exp %b", pix[0], {4'b0100, GRN}); end
    probe(0, 161, 241, 0);
    checks++; if (pix[0] !== {4'b0010, WHT}) begin errors++; $display("FAIL r_obj1 got %b exp %b", pix[0], {4'b0010, WHT}); end
  endtask

  task automatic test_stop;
    send(0, "D");
    tick(0, 1);
    send(0, "x");
    tick(0, 1);
    probe(0, 164, 241, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL stop_out got %b exp %b", pix[0], {4'b0000, NONE}); end
    probe(0, 165, 241, 0);
    checks++; if (pix[0] !== {4'b0010, WHT}) begin errors++; $display("FAIL stop_in got %b exp %b", pix[0], {4'b0010, WHT}); end
  endtask

  task automatic test_simultaneous;
    send(0, "r");
    send(0, "S");
    send(0, "2");
    send(0, "S");
    send(0, "1");
    @(negedge clk); rx_data[0] = "s"; rx_done[0] = 1'b1; frame_tick[0] = 1'b1;
    @(negedge clk); rx_done[0] = 1'b0; frame_tick[0] = 1'b0;
    $display("rx   dut0 byte 's' with frame_tick");
    probe(0, 200, 244, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL simul_obj1_out got %b exp %b", pix[0], {4'b0000, NONE}); end
    probe(0, 200, 245, 0);
    checks++; if (pix[0] !== {4'b0010, WHT}) begin errors++; $display("FAIL simul_obj1_in got %b exp %b", pix[0], {4'b0010, WHT}); end
    probe(0, 300, 244, 0);
    checks++; if (pix[0] !== {4'b0000, NONE}) begin errors++; $display("FAIL simul_obj2_out got %b exp %b", pix[0], {4'b0000, NONE}); end
    probe(0, 300, 245, 0);
    checks++; if (pix[0] !== {4'b0100, GRN}) begin errors++; $display("FAIL simul_obj2_in got %b exp %b", pix[0], {4'b0100, GRN}); end
    probe(0, 41, 241, 0);
    checks++; if (pix[0] !== {4'b0001, GRN}) begin errors++; $display("FAIL simul_obj0_still got %b exp %b", pix[0], {4'b0001, GRN}); end
    @(negedge clk); rx_data[0] = "r"; rx_done[0] = 1'b1; frame_tick[0] = 1'b1;
    @(negedge clk); rx_done[0] = 1'b0; frame_tick[0] = 1'b0;
    $display("rx   dut0 byte 'r' with frame_tick");
    probe(0, 200, 241, 0);
    checks++; if (pix[0] !== {4'b0010, WHT}) begin errors++; $display("FAIL r_tick_obj1 got %b exp %b", pix[0], {4'b0010, WHT}); end
    tick(0, 1);
    probe(0, 300, 241, 0);
    checks++; if (pix[0] !== {4'b0100, GRN}) begin errors++; $display("FAIL r_vel_zero got %b exp %b", pix[0], {4'b0100, GRN}); end
  endtask

  task automatic test_reset_mid;
    send(0, "0");
    send(0, "d");
    send(0, "3");
    @(negedge clk); reset = 1'b1; rx_data[0] = "d"; rx_done[0] = 1'b1;
    @(negedge clk); reset = 1'b0; rx_done[0] = 1'b0;
    $display("rst  with rx 'd' sel=%0d", sel_o[0]);
    checks++; if (sel_o[0] !== 3'd0) begin errors++; $display("FAIL mid_reset_sel got %0d exp 0", sel_o[0]); end
    probe(0, 41, 241, 0);
    checks++; if (pix[0] !== {4'b0001, WHT}) begin errors++; $display("FAIL mid_reset_obj0 got %b exp %b", pix[0], {4'b0001, WHT}); end
    probe(0, 401, 241, 0);
    checks++; if (pix[0] !== {4'b1000, GRN}) begin errors++; $display("FAIL mid_reset_obj3 got %b exp %b", pix[0], {4'b1000, GRN}); end
  endtask

  task automatic test_wrap;
    send(1, "a");
    probe(1, 1023, 241, 0);
    checks++; if (pix[1] !== {4'b0001, WHT}) begin errors++; $display("FAIL wrap_in got %b exp %b", pix[1], {4'b0001, WHT}); end
    probe(1, 1022, 241, 0);
    checks++; if (pix[1] !== {4'b0000, NONE}) begin errors++; $display("FAIL wrap_edge got %b exp %b", pix[1], {4'b0000, NONE}); end
    probe(1, 5, 241, 0);
    checks++; if (pix[1] !== {4'b0000, WHT}) begin errors++; $display("FAIL wrap_no_cmp_wrap got %b exp %b", pix[1], {4'b0000, WHT}); end
    send(1, "d");
    probe(1, 3, 241, 0);
    checks++; if (pix[1] !== {4'b0001, WHT}) begin errors++; $display("FAIL wrap_back got %b exp %b", pix[1], {4'b0001, WHT}); end
    send(1, "A");
    tick(1, 1);
    send(1, "x");
    probe(1, 1023, 241, 0);
    checks++; if (pix[1] !== {4'b0001, WHT}) begin errors++; $display("FAIL wrap_auto got %b exp %b", pix[1], {4'b0001, WHT}); end
  endtask

  task automatic test_clamp;
    send(2, "3");
    send(2, "D");
    tick(2, 200);
    checks++; if (sel_o[2] !== 3'd3) begin errors++; $display("FAIL clamp_sel got %0d exp 3", sel_o[2]); end
    probe(2, 541, 241, 0);
    checks++; if (pix[2] !== {4'b1000, WHT}) begin errors++; $display("FAIL clamp_x_in got %b exp %b", pix[2], {4'b1000, WHT}); end
    probe(2, 540, 241, 0);
    checks++; if (pix[2] !== {4'b0000, NONE}) begin errors++; $display("FAIL clamp_x_edge got %b exp %b", pix[2], {4'b0000, NONE}); end
    send(2, "a");
    tick(2, 1);
    probe(2, 537, 241, 0);
    checks++; if (pix[2] !== {4'b1000, WHT}) begin errors++; $display("FAIL clamp_vx_zero_in got %b exp %b", pix[2], {4'b1000, WHT}); end
    probe(2, 536, 241, 0);
    checks++; if (pix[2] !== {4'b0000, NONE}) begin errors++; $display("FAIL clamp_vx_zero_out got %b exp %b", pix[2], {4'b0000, NONE}); end
    send(2, "0");
    send_n(2, "a", 200);
    probe(2, 1, 241, 0);
    checks++; if (pix[2] !== {4'b0001, WHT}) begin errors++; $display("FAIL sat_zero_in got %b exp %b", pix[2], {4'b0001, WHT}); end
    probe(2, 0, 241, 0);
    checks++; if (pix[2] !== {4'b0000, NONE}) begin errors++; $display("FAIL sat_zero_edge got %b exp %b", pix[2], {4'b0000, NONE}); end
    probe(2, 1023, 241, 0);
    checks++; if (pix[2] !== {4'b0000, NONE}) begin errors++; $display("FAIL sat_no_wrap got %b exp %b", pix[2], {4'b0000, NONE}); end
    send_n(2, "s", 200);
    probe(2, 50, 381, 0);
    checks++; if (pix[2] !== {4'b0001, WHT}) begin errors++; $display("FAIL clamp_y_in got %b exp %b", pix[2], {4'b0001, WHT}); end
    probe(2, 50, 380, 0);
    checks++; if (pix[2] !== {4'b0000, NONE}) begin errors++; $display("FAIL clamp_y_edge got %b exp %b", pix[2], {4'b0000, NONE}); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rx_data[i] = 8'd0; rx_done[i] = 1'b0; px[i] = 10'd0; py[i] = 10'd0;
      blank[i] = 1'b1; frame_tick[i] = 1'b0;
    end
    test_reset;
    test_select_nudge;
    test_back_to_back;
    test_cmd_reset;
    test_stop;
    test_simultaneous;
    test_reset_mid;
    test_wrap;
    test_clamp;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_engine.md
# sprite_engine

Multi-object sprite controller and pixel colouriser for the VGA demo top level. It parses UART command bytes, which can select an object, nudge it, set its auto-velocity, stop it, or reset all objects. It keeps N_OBJ independent square objects with per-frame motion and edge handling in wrap or clamp mode, and draws the objects plus a screen border from the VGA timing outputs. It sits between `uart_top`/`vga` and the uio VGA output pins, replacing the single hard-coded object logic.

## Interface
- `N_OBJ`, default 4: number of objects, 1..8.
- `OBJ_SIZE`, default 100: object edge length in pixels.
- `STEP`, default 4: pixels per nudge and per frame of auto-motion.
- `H_RES` / `V_RES`, default 640 / 480: active area.
- `BORDER`, default 10: border thickness.
- `X0` / `X_PITCH` / `Y0`, default 40 / 120 / 240: reset position of object i is (X0+i·X_PITCH, Y0).
- `WRAP`, default 1: 1 = positions wrap modulo 1024; 0 = clamp to the active area.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `rx_data`  in  8: received UART byte, valid when `rx_done` is high.
- `rx_done`  in  1: one-cycle strobe from `uart_top`.
- `x`, `y`  in  10 each: current pixel coordinate from `vga`.
- `blank`  in  1: high outside the active area.
- `frame_tick`  in  1: one-cycle pulse, once per frame.
- `R`, `G`, `B`  out  2 each: registered pixel colour.
- `obj_hit`  out  N_OBJ: registered; bit i set when the pixel lies inside object i and `blank` is low.
- `sel`  out  3: index of the currently selected object.

## Operation
- State per object: `ox`, `oy` (10 bits each); `vx`, `vy` (each −1, 0 or +1).
- Global state: `sel`.
- Reset state: positions at their reset values; all velocities 0; `sel`=0; `R`/`G`/`B`/`obj_hit` = 0.
- Commands, acted on only when `rx_done` is high; every other byte is ignored:
  - '0'..'7' (48..55): `sel` ← digit, only if digit < N_OBJ; otherwise no change.
  - 'w'/'s' (119/115): `oy[sel]` ∓/± STEP.
  - 'a'/'d' (97/100): `ox[sel]` ∓/± STEP.
  - 'W'/'S' (87/83): `vy[sel]` ← −1 / +1. 'A'/'D' (65/68): `vx[sel]` ← −1 / +1.
  - 'x' (120): `vx[sel]` and `vy[sel]` ← 0.
  - 'r' (114): all positions and velocities return to reset values; `sel` is unchanged.
- Auto-motion on `frame_tick`: for every object, `ox += vx·STEP` and `oy += vy·STEP`.
- Edge rules:
  - WRAP=1: plain 10-bit modular arithmetic, e.g. 2−4 → 1022.
  - WRAP=0: x is clamped to [0, H_RES−OBJ_SIZE] and y to [0, V_RES−OBJ_SIZE]. Subtraction saturates at 0. Under auto-motion, a component that clamps has its velocity component zeroed.
- Simultaneous `rx_done` and `frame_tick`:
  - A position or velocity command applies to `sel`, and that object skips auto-motion this cycle. All other objects still move.
  - 'r' overrides auto-motion for every object.
  - A select command and auto-motion both apply; motion uses the old `sel` only for the skip rule.
- Pixel classification:
  - Inside object i: `x>ox & x<ox+OBJ_SIZE & y>oy & y<oy+OBJ_SIZE` (strict inequalities). The addition is 11 bits wide, with no wrap in the compare.
  - Border: `(x>0 & x<BORDER) | (x>H_RES−BORDER & x<H_RES) | (y>0 & y<BORDER) | (y>V_RES−BORDER & y<V_RES)`.
- Colour priority:
  1. `blank` → 0.
  2. Border → white (R=G=B=11).
  3. Selected object hit → white.
  4. Any other object hit → green (G=11, R=B=00).
  5. Otherwise → 0.

## Timing
- Command latency: state updates on the clock edge where `rx_done` is high and is visible the next cycle.
- `frame_tick` motion follows the same timing.
- Pixel pipeline: `R`/`G`/`B`/`obj_hit` at cycle n+1 reflect `x`/`y`/`blank` and the object state of cycle n. Latency is fixed at 1 cycle with no stalls.
- Back-to-back `rx_done` strobes on consecutive cycles are each processed.
- `sel` changes the cycle after the select byte.
- Reset asserted mid-operation: on the next edge, all state and outputs return to reset values, regardless of `rx_done` or `frame_tick` in that cycle.

## Test plan
- Reset: assert `reset` for 2 cycles, then sample pixel (41,241) with `blank`=0 → `obj_hit`=0001; `R`/`G`/`B` = white, because object 0 is selected. Pixel (161,241) → `obj_hit`=0010, green.
- Select and nudge: send '2' then 'd' → `sel`=2; object 2 spans x 285..383 (pixel (284,241) misses, (285,241) hits). Send '9' → `sel` stays 2.
- Wrap (WRAP=1, X0=2): send 'a' to object 0 → ox=1022; pixel (1023,241) → `obj_hit[0]`=1.
- Clamp (WRAP=0): give object 3 `vx`=+1, then 200 `frame_tick` pulses → ox=540 and `vx`=0. Send 'a' ×200 to object 0 → ox=0 and never wraps.
- Simultaneous events: object 1 with `vy`=+1; in the same cycle apply `rx_done`='s' (`sel`=1) and `frame_tick` → oy[1]=244, not 248. Object 2 with `vy`=+1 still moves by 4.
- Mid-operation reset: after the moves above, apply 'r' → all positions at their reset values and all velocities 0. Separately, assert `reset` in the same cycle as `rx_done`='d' → ox[sel] unchanged from its reset value, `sel`=0.
